rm_controller_fsm: RTL

- Multi-cycle control state machine that sequences the 16-bit datapath through register-file reads, ALU execution, status capture and register write-back.
- Drives ALUop, operand-select and load strobes into the datapath/ALU.
- Sits between the instruction register (opcode/op fields) and the datapath.
- Start/waiting handshake towards the top level.

---
 rtl/rm_controller_fsm_if.sv | 29 ++
 rtl/rm_controller_fsm.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rm_controller_fsm_if.sv
// Control bundle between rm_controller_fsm and the 16-bit datapath/instruction register.
// master = controller side, slave = datapath side.
interface rm_controller_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic [1:0] ALUop;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       halted;

    modport master (
        input  s, opcode, op,
        output w, nsel, vsel, loada, loadb, asel, bsel, ALUop, loadc, loads, write, halted
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, vsel, loada, loadb, asel, bsel, ALUop, loadc, loads, write, halted
    );
endinterface

// File: rtl/rm_controller_fsm.sv
// Multi-cycle Moore controller sequencing register reads, ALU execute and write-back.
// Optional sticky HALT on opcode 111 when RM_CTRL_HALT_EN is defined.
module rm_controller_fsm (
    input  logic                 clk,
    input  logic                 reset,
    rm_controller_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        EXEC      = 3'd5,
        WRITE_REG = 3'd6
`ifdef RM_CTRL_HALT_EN
        ,
        HALT      = 3'd7
`endif
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] opcode_l;
    logic [1:0] op_l;

    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic [1:0] aluop;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       halted;

    // Instruction fields are captured only on the start edge so later IR changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT;
            opcode_l <= 3'b000;
            op_l     <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == WAIT && bus.s) begin
                opcode_l <= bus.opcode;
                op_l     <= bus.op;
            end
        end
    end

    always_comb begin
        state_nxt = WAIT;
        w         = 1'b0;
        nsel      = 3'b000;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        aluop     = 2'b00;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        halted    = 1'b0;

        case (state)
            WAIT: begin
                w         = 1'b1;
                state_nxt = bus.s ? DECODE : WAIT;
            end
            DECODE: begin
                casez ({opcode_l, op_l})
                    5'b110_10:                       state_nxt = WRITE_IMM;
                    5'b110_00, 5'b101_11:            state_nxt = GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_nxt = GET_A;
`ifdef RM_CTRL_HALT_EN
                    5'b111_??:                       state_nxt = HALT;
`endif
                    default:                         state_nxt = WAIT;
                endcase
            end
            WRITE_IMM: begin
                nsel      = 3'b001;
                vsel      = 2'b10;
                write     = 1'b1;
                state_nxt = WAIT;
            end
            GET_A: begin
                nsel      = 3'b001;
                loada     = 1'b1;
                state_nxt = GET_B;
            end
            GET_B: begin
                nsel      = 3'b100;
                loadb     = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                // Only 101 (ALU ops) and 110/00 (MOV Rd,Rm: 0 + Rm) reach here.
                if (opcode_l == 3'b101) begin
                    aluop = op_l;
                    if (op_l == 2'b01) begin
                        loads     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        loadc     = 1'b1;
                        state_nxt = WRITE_REG;
                    end
                end else begin
                    asel      = 1'b1;
                    loadc     = 1'b1;
                    state_nxt = WRITE_REG;
                end
            end
            WRITE_REG: begin
                nsel      = 3'b010;
                write     = 1'b1;
                state_nxt = WAIT;
            end
`ifdef RM_CTRL_HALT_EN
            HALT: begin
                halted    = 1'b1;
                state_nxt = HALT;
            end
`endif
            default: state_nxt = WAIT;
        endcase
    end

    assign bus.w      = w;
    assign bus.nsel   = nsel;
    assign bus.vsel   = vsel;
    assign bus.loada  = loada;
    assign bus.loadb  = loadb;
    assign bus.asel   = asel;
    assign bus.bsel   = 1'b0;
    assign bus.ALUop  = aluop;
    assign bus.loadc  = loadc;
    assign bus.loads  = loads;
    assign bus.write  = write;
    assign bus.halted = halted;

endmodule
